// File: rtl/ema_xover_multi.sv
// Multi-channel fast/slow EMA crossover: per-tick HOLD/BUY/SELL and the position after the tick.
// Optional `EMA_DBG_EN adds fast_dbg/slow_dbg outputs. The sampling edge is k; the result is on edge k+2. There is no backpressure.
module ema_xover_multi #(
    parameter int NCH     = 4,
    parameter int W       = 32,
    parameter int FAST_SH = 2,
    parameter int SLOW_SH = 4,
    parameter int WARMUP  = 8,
    parameter int HYST    = 0,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_clear,
    input  logic          in_valid,
    input  logic [CW-1:0] in_ch,
    input  logic [W-1:0]  in_price,
    output logic          out_valid,
    output logic [CW-1:0] out_ch,
    output logic [1:0]    out_signal,
    output logic [1:0]    out_pos
`ifdef EMA_DBG_EN
    ,
    output logic [W-1:0]  fast_dbg,
    output logic [W-1:0]  slow_dbg
`endif
);
    localparam int CNTW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic signed [W:0] HYST_P = (W+1)'(HYST);
    localparam logic signed [W:0] HYST_N = -HYST_P;
    localparam logic [1:0] SIG_HOLD = 2'b00;
    localparam logic [1:0] SIG_BUY  = 2'b01;
    localparam logic [1:0] SIG_SELL = 2'b11;

    typedef enum logic [1:0] {FLAT = 2'b00, LONG = 2'b01, SHORT = 2'b11} pos_t;

    logic            init_q [NCH];
    logic [W-1:0]    fast_q [NCH];
    logic [W-1:0]    slow_q [NCH];
    logic [CNTW-1:0] cnt_q  [NCH];
    pos_t            pos_q  [NCH];

    logic                accept;
    logic [CW-1:0]       rd_ch;
    logic signed [W:0]   price_x, fast_x, slow_x, fast_sum, slow_sum, d_w;
    logic [W-1:0]        fast_d, slow_d;
    logic [CNTW-1:0]     cnt_d;
    logic                arm_d;
    logic                unused_bits;

    always_comb begin
        accept   = in_valid && (32'(in_ch) < 32'(NCH)) && !cfg_clear;
        rd_ch    = accept ? in_ch : '0;
        price_x  = {in_price[W-1], in_price};
        fast_x   = {fast_q[rd_ch][W-1], fast_q[rd_ch]};
        slow_x   = {slow_q[rd_ch][W-1], slow_q[rd_ch]};
        fast_sum = fast_x + ((price_x - fast_x) >>> FAST_SH);
        slow_sum = slow_x + ((price_x - slow_x) >>> SLOW_SH);
        fast_d   = init_q[rd_ch] ? fast_sum[W-1:0] : in_price;
        slow_d   = init_q[rd_ch] ? slow_sum[W-1:0] : in_price;
        d_w      = {fast_d[W-1], fast_d} - {slow_d[W-1], slow_d};
        // Warm-up is judged on the count before this tick; a fresh channel is never armed.
        arm_d    = init_q[rd_ch] && (32'(cnt_q[rd_ch]) >= 32'(WARMUP));
        cnt_d    = (32'(cnt_q[rd_ch]) < 32'(WARMUP)) ? cnt_q[rd_ch] + 1'b1 : cnt_q[rd_ch];
    end

    // The sum's carry bit is dropped on purpose: EMAs wrap to W bits.
    assign unused_bits = ^{fast_sum[W], slow_sum[W]};

    logic              s1_vld_q, s1_arm_q;
    logic [CW-1:0]     s1_ch_q;
    logic signed [W:0] s1_d_q;
`ifdef EMA_DBG_EN
    logic [W-1:0]      s1_fast_q, s1_slow_q, s2_fast_q, s2_slow_q, fast_dbg_q, slow_dbg_q;
`endif
    logic              s2_vld_q;
    logic [CW-1:0]     s2_ch_q;
    logic [1:0]        s2_sig_q, s2_pos_q;
    logic              out_valid_q;
    logic [CW-1:0]     out_ch_q;
    logic [1:0]        out_signal_q, out_pos_q;

    pos_t       pos_cur, pos_nx;
    logic [1:0] sig_d;

    always_comb begin
        pos_cur = pos_q[s1_ch_q];
        pos_nx  = pos_cur;
        sig_d   = SIG_HOLD;
        if (s1_arm_q) begin
            if (s1_d_q > HYST_P) begin
                if (pos_cur != LONG) begin
                    pos_nx = LONG;
                    sig_d  = SIG_BUY;
                end
            end else if (s1_d_q < HYST_N) begin
                if (pos_cur != SHORT) begin
                    pos_nx = SHORT;
                    sig_d  = SIG_SELL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                init_q[i] <= 1'b0;
                fast_q[i] <= '0;
                slow_q[i] <= '0;
                cnt_q[i]  <= '0;
                pos_q[i]  <= FLAT;
            end
        end else if (cfg_clear) begin
            for (int i = 0; i < NCH; i++) begin
                init_q[i] <= 1'b0;
                fast_q[i] <= '0;
                slow_q[i] <= '0;
                cnt_q[i]  <= '0;
                pos_q[i]  <= FLAT;
            end
        end else begin
            if (accept) begin
                init_q[rd_ch] <= 1'b1;
                fast_q[rd_ch] <= fast_d;
                slow_q[rd_ch] <= slow_d;
                cnt_q[rd_ch]  <= cnt_d;
            end
            if (s1_vld_q) pos_q[s1_ch_q] <= pos_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q     <= 1'b0;
            s1_arm_q     <= 1'b0;
            s1_ch_q      <= '0;
            s1_d_q       <= '0;
            s2_vld_q     <= 1'b0;
            s2_ch_q      <= '0;
            s2_sig_q     <= '0;
            s2_pos_q     <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_signal_q <= '0;
            out_pos_q    <= '0;
`ifdef EMA_DBG_EN
            s1_fast_q    <= '0;
            s1_slow_q    <= '0;
            s2_fast_q    <= '0;
            s2_slow_q    <= '0;
            fast_dbg_q   <= '0;
            slow_dbg_q   <= '0;
`endif
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_arm_q <= arm_d;
                s1_ch_q  <= rd_ch;
                s1_d_q   <= d_w;
`ifdef EMA_DBG_EN
                s1_fast_q <= fast_d;
                s1_slow_q <= slow_d;
`endif
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_ch_q  <= s1_ch_q;
                s2_sig_q <= sig_d;
                s2_pos_q <= pos_nx;
`ifdef EMA_DBG_EN
                s2_fast_q <= s1_fast_q;
                s2_slow_q <= s1_slow_q;
`endif
            end
            out_valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_ch_q     <= s2_ch_q;
                out_signal_q <= s2_sig_q;
                out_pos_q    <= s2_pos_q;
`ifdef EMA_DBG_EN
                fast_dbg_q   <= s2_fast_q;
                slow_dbg_q   <= s2_slow_q;
`endif
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_signal = out_signal_q;
    assign out_pos    = out_pos_q;
`ifdef EMA_DBG_EN
    assign fast_dbg   = fast_dbg_q;
    assign slow_dbg   = slow_dbg_q;
`endif
endmodule

// File: tb/tb_ema_xover_multi.sv
// Randomised + directed bench for ema_xover_multi; expected results come from a per-channel model.
module tb_ema_xover_multi;
    localparam int NCH     = 3;
    localparam int W       = 32;
    localparam int FAST_SH = 2;
    localparam int SLOW_SH = 4;
    localparam int WARMUP  = 8;
    localparam int HYST    = 32'h0001_0000;
    localparam int P100    = 32'h0064_0000;
    localparam int P110    = 32'h006E_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_ch = '0;
    logic [W-1:0] in_price = '0;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [1:0]  out_signal;
    logic [1:0]  out_pos;
`ifdef EMA_DBG_EN
    logic [W-1:0] fast_dbg, slow_dbg;
`endif

    ema_xover_multi #(.NCH(NCH), .W(W), .FAST_SH(FAST_SH), .SLOW_SH(SLOW_SH),
                      .WARMUP(WARMUP), .HYST(HYST)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_clear(cfg_clear), .in_valid(in_valid),
        .in_ch(in_ch), .in_price(in_price), .out_valid(out_valid), .out_ch(out_ch),
        .out_signal(out_signal), .out_pos(out_pos)
`ifdef EMA_DBG_EN
        , .fast_dbg(fast_dbg), .slow_dbg(slow_dbg)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         ch;
        logic [1:0] sig;
        logic [1:0] pos;
        int         fast;
        int         slow;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    // Reference model: per-channel state in plain integers; position is +1/0/-1.
    bit m_init [NCH];
    int m_fast [NCH];
    int m_slow [NCH];
    int m_cnt  [NCH];
    int m_pos  [NCH];

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_init[i] = 0; m_fast[i] = 0; m_slow[i] = 0; m_cnt[i] = 0; m_pos[i] = 0;
        end
    endtask

    task automatic model_tick(input int ch, input int price);
        exp_t   e;
        longint p, d;
        int     sig;
        bit     armed;
        p = price;
        armed = m_init[ch] && (m_cnt[ch] >= WARMUP);
        if (!m_init[ch]) begin
            m_fast[ch] = price;
            m_slow[ch] = price;
        end else begin
            m_fast[ch] = int'(longint'(m_fast[ch]) + ((p - m_fast[ch]) >>> FAST_SH));
            m_slow[ch] = int'(longint'(m_slow[ch]) + ((p - m_slow[ch]) >>> SLOW_SH));
        end
        m_init[ch] = 1;
        if (m_cnt[ch] < WARMUP) m_cnt[ch]++;
        d = longint'(m_fast[ch]) - longint'(m_slow[ch]);
        sig = 0;
        if (armed) begin
            if (d > HYST && m_pos[ch] != 1) begin
                m_pos[ch] = 1; sig = 1;
            end else if (d < -longint'(HYST) && m_pos[ch] != -1) begin
                m_pos[ch] = -1; sig = -1;
            end
        end
        e.ch = ch; e.sig = 2'(sig); e.pos = 2'(m_pos[ch]);
        e.fast = m_fast[ch]; e.slow = m_slow[ch]; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic drive(input bit vld, input int ch, input int price, input bit clr);
        @(negedge clk);
        in_valid = vld; in_ch = 2'(ch); in_price = price; cfg_clear = clr;
        if (clr) model_clear();
        else if (vld && ch < NCH) model_tick(ch, price);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 1'b0);
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("out_ch", 64'(out_ch), 64'(e.ch));
                check_eq("out_signal", 64'(out_signal), 64'(e.sig));
                check_eq("out_pos", 64'(out_pos), 64'(e.pos));
                // Issued before sampling edge k; visible after edge k+2.
                check_eq("latency", 64'(cyc - e.cyc), 64'(3));
`ifdef EMA_DBG_EN
                check_eq("fast_dbg", 64'(fast_dbg), 64'(unsigned'(e.fast)));
                check_eq("slow_dbg", 64'(slow_dbg), 64'(unsigned'(e.slow)));
`endif
            end
        end
    end

    int wp [NCH];

    initial begin
        model_clear();
        #12;
        check_eq("rst_valid", 64'(out_valid), 64'(0));
        check_eq("rst_sig_pos_ch", 64'({out_signal, out_pos, out_ch}), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        // Seeding and steady price.
        for (int i = 0; i < 3; i++) begin drive(1, 0, P100, 0); idle(2); end
        // Warm-up then crossover: 10 ticks at 100.0, then 110.0 twice.
        for (int i = 0; i < 7; i++) drive(1, 0, P100, 0);
        drive(1, 0, P110, 0);
        drive(1, 0, P110, 0);
        idle(4);

        // Clear with a same-cycle tick on ch2, then reseed ch2.
        drive(1, 1, P100, 0);
        drive(1, 2, P110, 1);
        drive(1, 2, P100, 0);
        idle(4);

        // Interleaved ch0 rising / ch1 falling, one tick per cycle.
        drive(1, 2, P100, 1);
        for (int i = 0; i < 10; i++) begin drive(1, 0, P100, 0); drive(1, 1, P100, 0); end
        for (int i = 1; i <= 12; i++) begin
            drive(1, 0, P100 + i * 32'h0000_8000, 0);
            drive(1, 1, P100 - i * 32'h0000_8000, 0);
        end
        idle(4);

        // Dead band on ch2: slow ramp up, then back down.
        for (int i = 0; i < 9; i++) drive(1, 2, P100, 0);
        for (int i = 1; i <= 10; i++) drive(1, 2, P100 + i * 32'h0000_4000, 0);
        for (int i = 1; i <= 6; i++) drive(1, 2, P100 + 32'h0002_8000 - i * 32'h0000_6000, 0);
        idle(4);

        // Bad channel id is dropped.
        drive(1, 3, P110, 0);
        drive(1, 3, P100, 0);
        idle(4);

        // Reset with results in flight.
        drive(1, 2, P100, 0);
        drive(1, 0, P100, 0);
        drive(1, 1, P100, 0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(out_valid), 64'(0));
        check_eq("async_rst_fields", 64'({out_signal, out_pos, out_ch}), 64'(0));
        sb.delete();
        model_clear();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Randomised traffic: random walks per channel, bad ids, clears, wild jumps.
        for (int i = 0; i < NCH; i++) wp[i] = P100;
        for (int n = 0; n < 1500; n++) begin
            int r, ch, price;
            r = $urandom_range(0, 99);
            ch = $urandom_range(0, 3);
            if (ch < NCH) begin
                wp[ch] = wp[ch] + $urandom_range(0, 32'h0004_0000) - 32'h0002_0000;
                price = wp[ch];
            end else begin
                price = $urandom;
            end
            if (r < 3) price = $urandom;
            if (r < 10) drive(1'b0, 0, 0, 1'b0);
            else if (r < 12) drive(1'b1, ch, price, 1'b1);
            else drive(1'b1, ch, price, 1'b0);
        end
        idle(8);
        check_eq("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
